// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings.
package barrel_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_ROL = 2'b00,
    MODE_ROR = 2'b01,
    MODE_LSL = 2'b10,
    MODE_LSR = 2'b11
  } mode_t;

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter level: conditionally moves the operand by 2^K and
// registers the result together with its valid, mode, amount and zero flag.
module shifter_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 0,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_data,
  input  mode_t            prev_mode,
  input  logic [SW-1:0]    prev_amt,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  output mode_t            mode,
  output logic [SW-1:0]    amt,
  output logic             zero
);

  localparam int DIST = 2 ** K;

  logic [WIDTH-1:0] result;

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input mode_t m);
    unique case (m)
      MODE_ROL: shift_level = (d << DIST) | (d >> (WIDTH - DIST));
      MODE_ROR: shift_level = (d >> DIST) | (d << (WIDTH - DIST));
      MODE_LSL: shift_level = d << DIST;
      default:  shift_level = d >> DIST;
    endcase
  endfunction

  assign result = prev_amt[K] ? shift_level(prev_data, prev_mode) : prev_data;

  // Stage register: every level moves on the shared advance, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
      mode <= MODE_ROL;
      amt  <= '0;
      zero <= 1'b0;
    end else if (advance) begin
      vld  <= prev_vld;
      data <= result;
      mode <= prev_mode;
      amt  <= prev_amt;
      zero <= (result == '0);
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined rotate/shift unit: SW registered levels with a global stall,
// valid/ready handshake on both sides and a registered all-zero flag.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic             advance;
  logic             vld_p  [0:SW];
  logic [WIDTH-1:0] data_p [0:SW];
  mode_t            mode_p [0:SW];
  logic [SW-1:0]    amt_p  [0:SW];
  logic             zero_p [1:SW];

  // Whole pipe advances unless the output slot is full and not being taken
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  assign vld_p[0]  = in_valid && in_ready;
  assign data_p[0] = in_data;
  assign mode_p[0] = mode_t'(in_mode);
  assign amt_p[0]  = in_amt;

  for (genvar k = 0; k < SW; k++) begin : g_level
    shifter_stage #(
      .WIDTH (WIDTH),
      .K     (k),
      .SW    (SW)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .prev_vld  (vld_p[k]),
      .prev_data (data_p[k]),
      .prev_mode (mode_p[k]),
      .prev_amt  (amt_p[k]),
      .vld       (vld_p[k+1]),
      .data      (data_p[k+1]),
      .mode      (mode_p[k+1]),
      .amt       (amt_p[k+1]),
      .zero      (zero_p[k+1])
    );
  end

  assign out_valid = vld_p[SW];
  assign out_data  = data_p[SW];
  assign out_zero  = zero_p[SW];

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; SHALL be a power of two, 2..64.
REQ-002 Parameter: SW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  input beat present.
REQ-006 Port: in_ready  output  1  block can accept an input beat.
REQ-007 Port: in_data  input  WIDTH  operand.
REQ-008 Port: in_amt  input  SW  shift/rotate distance, 0..WIDTH-1.
REQ-009 Port: in_mode  input  2  operation: 00 ROL, 01 ROR, 10 LSL, 11 LSR.
REQ-010 Port: out_valid  output  1  result beat present.
REQ-011 Port: out_ready  input  1  downstream accepts the result beat.
REQ-012 Port: out_data  output  WIDTH  result.
REQ-013 Port: out_zero  output  1  high when out_data is all zeros.

Function
REQ-014 ROL SHALL give out_data[i] = in_data[(i - amt) mod WIDTH]; ROR SHALL give out_data[i] = in_data[(i + amt) mod WIDTH].
REQ-015 LSL and LSR SHALL shift by amt and zero-fill vacated bits; no carry out.
REQ-016 amt = 0 SHALL pass in_data through unchanged in every mode.
REQ-017 The datapath SHALL be SW levels; level k shifts by 2^k when amt bit k is set; each level is followed by a register.
REQ-018 Latency SHALL be exactly SW cycles from an accepted input to out_valid when no stall occurs (3 cycles for WIDTH=8).
REQ-019 Mode and amt SHALL travel with the data through the pipe; each beat uses its own mode/amt regardless of later inputs.
REQ-020 A beat SHALL be accepted when in_valid && in_ready; it SHALL be consumed when out_valid && out_ready.
REQ-021 Pipeline advance = !out_valid || out_ready; all levels SHALL shift together on advance and hold otherwise (global stall).
REQ-022 in_ready SHALL equal advance, and SHALL be 0 while rst is high.
REQ-023 Bubbles (advance with in_valid low) SHALL propagate as invalid slots; they are not collapsed.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_zero and out_valid SHALL be held stable.
REQ-025 Simultaneous accept and consume in one cycle SHALL be sustained; full throughput is one beat per cycle.
REQ-026 out_zero SHALL be computed from the final-level result and be registered with it.

Reset
REQ-027 When rst is high at a clock edge, every stage valid bit SHALL clear; out_valid=0, out_data=0 and out_zero=0 from the next cycle.
REQ-028 A beat in flight when rst is asserted SHALL be discarded and never appear at the output.
REQ-029 Inputs presented while rst is high SHALL be ignored.
REQ-030 The first beat after rst deasserts SHALL be accepted on the first cycle in which in_valid is high.

Structure
REQ-031 The mode encodings (ROL/ROR/LSL/LSR) SHALL be constants in the shared package barrel_shifter_pkg.
REQ-032 One level SHALL be a sub-module shifter_stage, parameterised by WIDTH and level index k, and instantiated SW times via generate.

Verification
REQ-033 WIDTH=8, ROL 0x96 amt 3 -> out_data 0xB4 exactly 3 cycles after accept, out_zero=0.
REQ-034 WIDTH=8, back-to-back ROR 0x96/3, LSL 0x96/3, LSR 0x96/3 -> 0xD2, 0xB0, 0x12 on consecutive cycles.
REQ-035 WIDTH=8, LSL 0x80 amt 1 -> 0x00 with out_zero=1; any mode with amt 0 on 0x5A -> 0x5A.
REQ-036 Stream 5 beats with out_ready low for 4 cycles after the first out_valid -> in_ready low during the stall, out_data held, all 5 results in order, none lost or duplicated.
REQ-037 Assert rst for 1 cycle with 2 beats in flight -> out_valid stays 0; the next accepted beat emerges alone after 3 cycles.
REQ-038 WIDTH=32, random mode/amt/data for 10k beats with random out_ready -> every result matches a reference model, in order.
